// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder used as the per-bit datapath of the serial engine.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract: one bit per SHIFT cycle, LSB first, result
// and flags registered when DONE is entered.
module serial_addsub_seq
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output state_t           fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_q;
  logic             bit_s, bit_co;

  // Handshake: start is a one-cycle request honoured only while IDLE
  // (busy and done both low); busy covers the WIDTH SHIFT cycles and
  // done pulses for one cycle when sum/cout/ovf are valid.
  full_adder_1bit u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0] ^ sub_q),
    .cin (carry),
    .s   (bit_s),
    .co  (bit_co)
  );

  assign res_next  = {bit_s, res_sh};
  assign fsm_state = state;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) next_state = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin ^ sub;
        cnt   <= '0;
        sub_q <= sub;
      end else if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_next[WIDTH-1:1];
        carry  <= bit_co;
        cnt    <= cnt + CW'(1);
        // Last bit: carry still holds the carry into the MSB.
        if (cnt == LAST_BIT) begin
          sum  <= res_next;
          cout <= bit_co;
          ovf  <= carry ^ bit_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Bench for serial_addsub_seq: directed WIDTH=4 cases plus random runs at
// WIDTH=8 and WIDTH=32 against an arithmetic model.
module tb_serial_addsub_seq;
  import serial_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // WIDTH=4 instance
  logic start4 = 0, cin4 = 0, sub4 = 0;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic cout4, ovf4, busy4, done4;
  state_t st4;
  // WIDTH=8 instance
  logic start8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic cout8, ovf8, busy8, done8;
  state_t st8;
  // WIDTH=32 instance
  logic start32 = 0, cin32 = 0, sub32 = 0;
  logic [31:0] a32 = 0, b32 = 0, sum32;
  logic cout32, ovf32, busy32, done32;
  state_t st32;

  serial_addsub_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .sub(sub4), .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4),
    .done(done4), .fsm_state(st4));
  serial_addsub_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sub(sub8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8),
    .done(done8), .fsm_state(st8));
  serial_addsub_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .sub(sub32), .sum(sum32), .cout(cout32), .ovf(ovf32), .busy(busy32),
    .done(done32), .fsm_state(st32));

  logic [33:0] exp_q4[$];
  logic [33:0] exp_q8[$];
  logic [33:0] exp_q32[$];

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result packed as {ovf, cout, sum[31:0]} from plain integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] op_a,
                                        input logic [31:0] op_b, input logic ci,
                                        input logic is_sub);
    longint mask, half, ua, ub, u, sa, sb, t, c;
    logic [31:0] s;
    logic co, ov;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = {32'b0, op_a} & mask;
    ub = {32'b0, op_b} & mask;
    c  = ci ? 1 : 0;
    u  = is_sub ? ua + ((~ub) & mask) + (1 - c) : ua + ub + c;
    s  = 32'(u & mask);
    co = ((u >> w) & 1) != 0;
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    t  = is_sub ? sa - sb - c : sa + sb + c;
    ov = (t >= half) || (t < -half);
    return {ov, co, s};
  endfunction

  // Scoreboards: pop on done, otherwise outputs must hold the last result.
  logic [33:0] last4 = '0, last8 = '0, last32 = '0;
  always @(negedge clk) begin
    if (!rst_n) last4 = '0;
    else if (done4) begin
      if (exp_q4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done4: got done=1 required no done");
      end else begin
        last4 = exp_q4.pop_front();
        check("result4", {ovf4, cout4, 28'b0, sum4}, last4);
      end
    end else check("hold4", {ovf4, cout4, 28'b0, sum4}, last4);
  end
  always @(negedge clk) begin
    if (!rst_n) last8 = '0;
    else if (done8) begin
      if (exp_q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done8: got done=1 required no done");
      end else begin
        last8 = exp_q8.pop_front();
        check("result8", {ovf8, cout8, 24'b0, sum8}, last8);
      end
    end else check("hold8", {ovf8, cout8, 24'b0, sum8}, last8);
  end
  always @(negedge clk) begin
    if (!rst_n) last32 = '0;
    else if (done32) begin
      if (exp_q32.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done32: got done=1 required no done");
      end else begin
        last32 = exp_q32.pop_front();
        check("result32", {ovf32, cout32, sum32}, last32);
      end
    end else check("hold32", {ovf32, cout32, sum32}, last32);
  end

  // Issue one WIDTH=4 operation and wait for done; literals pin the model.
  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic ci,
                      input logic is_sub, input logic [3:0] es, input logic ec,
                      input logic eo);
    logic [33:0] m;
    int cyc;
    m = model(4, {28'b0, ta}, {28'b0, tb}, ci, is_sub);
    check("model4", m, {eo, ec, 28'b0, es});
    exp_q4.push_back(m);
    @(negedge clk);
    a4 = ta; b4 = tb; cin4 = ci; sub4 = is_sub; start4 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      cyc++;
      if (cyc == 1) check("busy4_c1", {33'b0, busy4}, 34'd1);
    end while (!done4 && cyc < 40);
    check("latency4", 34'(cyc), 34'd5);
    check("lit4", {ovf4, cout4, 28'b0, sum4}, {eo, ec, 28'b0, es});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dones;
    repeat (3) @(negedge clk);
    check("reset_out4", {busy4, done4, ovf4, cout4, 26'b0, sum4, 2'(st4)}, 34'd0);
    check("reset_out32", {ovf32, cout32, sum32}, 34'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    run4(4'b0001, 4'b0010, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0);
    run4(4'b0101, 4'b0011, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b1);
    run4(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
    run4(4'b0101, 4'b0011, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0);
    run4(4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0);

    // Start pulsed while busy must be ignored.
    exp_q4.push_back(model(4, 32'd1, 32'd2, 1'b0, 1'b0));
    @(negedge clk);
    a4 = 4'b0001; b4 = 4'b0010; cin4 = 0; sub4 = 0; start4 = 1'b1;
    dones = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start4 = (i == 2);
      if (i == 2) begin a4 = 4'b1010; b4 = 4'b0101; end
      if (done4) dones++;
      if (i == 5) check("ign_done_c5", {33'b0, done4}, 34'd1);
    end
    check("ign_done_count", 34'(dones), 34'd1);
    check("ign_sum", {ovf4, cout4, 28'b0, sum4}, 34'h0_0000_0003);

    // Reset in the middle of SHIFT.
    run4(4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0);
    exp_q4.push_back(model(4, 32'd7, 32'd1, 1'b0, 1'b0));
    @(negedge clk);
    a4 = 4'b0111; b4 = 4'b0001; cin4 = 0; sub4 = 0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    check("busy4_mid", {33'b0, busy4}, 34'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {33'b0, busy4}, 34'd0);
    check("rst_sum", {30'b0, sum4}, 34'd0);
    check("rst_state", {32'b0, 2'(st4)}, {32'b0, 2'(IDLE)});
    exp_q4.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    run4(4'b0110, 4'b0001, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0);

    // Random back-to-back operations at WIDTH=8 and WIDTH=32.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] ra, rb;
          logic rc, rs;
          int c8;
          ra = 8'($urandom); rb = 8'($urandom);
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          exp_q8.push_back(model(8, {24'b0, ra}, {24'b0, rb}, rc, rs));
          @(negedge clk);
          a8 = ra; b8 = rb; cin8 = rc; sub8 = rs; start8 = 1'b1;
          c8 = 0;
          do begin
            @(negedge clk);
            start8 = 1'b0;
            c8++;
          end while (!done8 && c8 < 60);
          check("latency8", 34'(c8), 34'd9);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] ra, rb;
          logic rc, rs;
          int c32;
          ra = $urandom; rb = $urandom;
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          exp_q32.push_back(model(32, ra, rb, rc, rs));
          @(negedge clk);
          a32 = ra; b32 = rb; cin32 = rc; sub32 = rs; start32 = 1'b1;
          c32 = 0;
          do begin
            @(negedge clk);
            start32 = 1'b0;
            c32++;
          end while (!done32 && c32 < 80);
          check("latency32", 34'(c32), 34'd33);
        end
      end
    join

    repeat (3) @(negedge clk);
    check("drain4", 34'(exp_q4.size()), 34'd0);
    check("drain8", 34'(exp_q8.size()), 34'd0);
    check("drain32", 34'(exp_q32.size()), 34'd0);
    cyc = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub_seq.md
SERIAL_ADDSUB_SEQ -- requirements
Module: serial_addsub_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range is 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin an operation.
REQ-005 a  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 b  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 cin  input  1  carry-in (add) or borrow-in (subtract), sampled on an accepted start.
REQ-008 sub  input  1  mode select (0 = add, 1 = subtract), sampled on an accepted start.
REQ-009 sum  output  WIDTH  result, registered.
REQ-010 cout  output  1  carry out of the MSB; in subtract mode 1 means no borrow.
REQ-011 ovf  output  1  two's-complement signed overflow.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse when the result is valid.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 Transitions SHALL be IDLE->SHIFT on start, SHIFT->DONE after exactly WIDTH SHIFT cycles, and DONE->IDLE unconditionally.
REQ-016 Start SHALL be accepted only in IDLE; start in SHIFT or DONE SHALL be ignored with no effect on state or data.
REQ-017 On acceptance: A and B shift registers load a and b, the carry flip-flop loads cin XOR sub, the bit counter clears, and sub is latched.
REQ-018 Each SHIFT cycle SHALL process one bit, LSB first:
  - form s = A[0] ^ B'[0] ^ c, where B' = B inverted when the latched sub = 1;
  - update c with the majority function;
  - shift s into the result register from the MSB side;
  - shift A and B right by one.
REQ-019 Arithmetic: add SHALL give a+b+cin; subtract SHALL give a+~b+~cin, i.e. a-b-cin, all modulo 2^WIDTH.
REQ-020 cout SHALL equal the final carry; ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 busy SHALL be high in SHIFT only.
REQ-022 done SHALL be high in DONE only, in the cycle WIDTH+1 after the start cycle.
REQ-023 sum, cout and ovf SHALL change only when DONE is entered and SHALL hold until the next DONE.
REQ-024 A back-to-back start, asserted in the cycle after done, SHALL be accepted; the minimum issue interval is WIDTH+2 cycles.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL not wrap within one operation.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, clear sum, cout, ovf, busy and done, clear the carry, counter and shift registers, and abort any operation in progress.
REQ-027 After reset deassertion, the first start SHALL be honoured on the next rising edge.

Structure
REQ-028 Package serial_addsub_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-029 The per-bit logic SHALL be the sub-module full_adder_1bit (inputs a, b, cin; outputs s, co), instantiated once.

Verification
REQ-030 The bench SHALL run at WIDTH=4 unless stated otherwise, and SHALL cover:
  - Add a=0001, b=0010, cin=0 -> done at cycle 5, sum=0011, cout=0, ovf=0.
  - Add a=0101, b=0011, cin=1 -> sum=1001, cout=0, ovf=1.
  - Add a=1111, b=1111, cin=1 -> sum=1111, cout=1, ovf=0.
  - Subtract a=0101, b=0011, cin=0 -> sum=0010, cout=1; subtract a=0011, b=0101 -> sum=1110, cout=0.
  - start pulsed during busy with a=1010, b=0101 -> ignored; first result unchanged, with exactly one done pulse.
  - rst_n low mid-SHIFT -> busy=0, sum=0 immediately; a new start then completes in 5 cycles.
REQ-031 A randomized check SHALL compare 1000 operations at WIDTH=8 and WIDTH=32 against a behavioural model.
